// File: rtl/fixed_leaky_relu_pipelined.sv
// Purpose: per-lane ReLU / LeakyReLU / identity on signed fixed-point lanes with rescale, rounding and saturation.
// Latency: 2 cycles from input handshake to data_out_0_valid; one beat per cycle when unstalled.
// Backpressure: valid/ready skid-free pipeline; a full stage holds its data and bubbles collapse.
module fixed_leaky_relu_pipelined #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 4,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 4,
    parameter int DATA_OUT_0_PARALLELISM_DIM_1 = 1,
    parameter int NEGATIVE_SLOPE_PRECISION_0 = 8,
    parameter int NEGATIVE_SLOPE_PRECISION_1 = 7,
    parameter int NEGATIVE_SLOPE_VALUE       = 13,
    parameter int ROUNDING                   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    input  logic                              cfg_valid,
    input  logic [NEGATIVE_SLOPE_PRECISION_0-1:0] cfg_slope,
    input  logic [1:0]                        cfg_mode
);

    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int W_IN  = DATA_IN_0_PRECISION_0;
    localparam int F_IN  = DATA_IN_0_PRECISION_1;
    localparam int W_S   = NEGATIVE_SLOPE_PRECISION_0;
    localparam int F_S   = NEGATIVE_SLOPE_PRECISION_1;
    localparam int W_OUT = DATA_OUT_0_PRECISION_0;
    localparam int F_OUT = DATA_OUT_0_PRECISION_1;
    localparam int W_P   = W_IN + W_S;
    // One bit of headroom over the widest operand so the rounding add never wraps.
    localparam int W_E   = ((W_P > W_OUT) ? W_P : W_OUT) + 1;
    localparam int SH_X  = F_IN - F_OUT;
    localparam int SH_P  = F_IN + F_S - F_OUT;

    localparam logic signed [W_E-1:0] OUT_MAX = {{(W_E-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_E-1:0] OUT_MIN = {{(W_E-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;

    if (F_OUT > F_IN
        || DATA_OUT_0_TENSOR_SIZE_DIM_0 != DATA_IN_0_TENSOR_SIZE_DIM_0
        || DATA_OUT_0_TENSOR_SIZE_DIM_1 != DATA_IN_0_TENSOR_SIZE_DIM_1
        || DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0
        || DATA_OUT_0_PARALLELISM_DIM_1 != DATA_IN_0_PARALLELISM_DIM_1) begin : g_bad_params
        $error("fixed_leaky_relu_pipelined: output format must not add fraction bits and shapes must match");
    end

    // Arithmetic right shift by sh, optionally rounding half up first.
    function automatic logic signed [W_E-1:0] rescale(input logic signed [W_E-1:0] v, input int sh);
        logic signed [W_E-1:0] half;
        half = (ROUNDING != 0 && sh > 0) ? (W_E'(1) << (sh - 1)) : '0;
        return (v + half) >>> sh;
    endfunction

    // Clamp into the signed output range.
    function automatic logic [W_OUT-1:0] saturate(input logic signed [W_E-1:0] v);
        if (v > OUT_MAX)      return OUT_MAX[W_OUT-1:0];
        else if (v < OUT_MIN) return OUT_MIN[W_OUT-1:0];
        else                  return v[W_OUT-1:0];
    endfunction

    logic signed [W_S-1:0] slope_reg;
    logic [1:0]            mode_reg;

    logic                  s1_valid;
    logic signed [W_IN-1:0] s1_x [N];
    logic signed [W_P-1:0]  s1_p [N];
    logic [N-1:0]          s1_neg;
    logic [1:0]            s1_mode;

    logic signed [W_P-1:0] prod   [N];
    logic [W_OUT-1:0]      s2_res [N];

    logic s1_ready;
    logic s2_ready;

    assign s2_ready        = !data_out_0_valid || data_out_0_ready;
    assign s1_ready        = !s1_valid || s2_ready;
    assign data_in_0_ready = s1_ready;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [W_E-1:0] x_e;
        logic signed [W_E-1:0] p_e;
        logic                  use_p;
        logic                  use_zero;

        // Full-precision product at F_IN+F_S fraction bits.
        assign prod[i] = $signed({{W_S{data_in_0[i][W_IN-1]}}, data_in_0[i]})
                       * $signed({{W_IN{slope_reg[W_S-1]}}, slope_reg});

        assign x_e      = {{(W_E-W_IN){s1_x[i][W_IN-1]}}, s1_x[i]};
        assign p_e      = {{(W_E-W_P){s1_p[i][W_P-1]}}, s1_p[i]};
        assign use_p    = s1_neg[i] && (s1_mode == MODE_LEAKY);
        assign use_zero = s1_neg[i] && (s1_mode == MODE_RELU);

        assign s2_res[i] = use_p    ? saturate(rescale(p_e, SH_P)) :
                           use_zero ? '0 :
                                      saturate(rescale(x_e, SH_X));
    end

    // Run-time configuration; a beat accepted this cycle already captured the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            slope_reg <= W_S'(NEGATIVE_SLOPE_VALUE);
            mode_reg  <= MODE_LEAKY;
        end else if (cfg_valid) begin
            slope_reg <= cfg_slope;
            mode_reg  <= cfg_mode;
        end
    end

    // Stage 1 occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= data_in_0_valid;
        end
    end

    // Stage 1 payload: product, raw input, sign and the mode in force when the beat arrived.
    always_ff @(posedge clk) begin
        if (data_in_0_valid && s1_ready) begin
            for (int i = 0; i < N; i++) begin
                s1_x[i]   <= data_in_0[i];
                s1_p[i]   <= prod[i];
                s1_neg[i] <= data_in_0[i][W_IN-1];
            end
            s1_mode <= mode_reg;
        end
    end

    // Stage 2: registered output, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_0_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                data_out_0[i] <= '0;
            end
        end else if (s2_ready) begin
            data_out_0_valid <= s1_valid;
            if (s1_valid) begin
                for (int i = 0; i < N; i++) begin
                    data_out_0[i] <= s2_res[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_leaky_relu_pipelined.sv
module tb_fixed_leaky_relu_pipelined;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [N-1:0];
    logic       in_vld;
    logic       out_rdy;
    logic       cfg_v;
    logic [7:0] cfg_s;
    logic [1:0] cfg_m;

    logic       in_rdy0, in_rdy1, in_rdy2;
    logic       ov0, ov1, ov2;
    logic [7:0] dout0 [N-1:0];
    logic [7:0] dout1 [N-1:0];
    logic [5:0] dout2 [N-1:0];

    always #5 clk = ~clk;

    fixed_leaky_relu_pipelined dut_floor (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(in_vld), .data_in_0_ready(in_rdy0),
        .data_out_0(dout0), .data_out_0_valid(ov0), .data_out_0_ready(out_rdy),
        .cfg_valid(cfg_v), .cfg_slope(cfg_s), .cfg_mode(cfg_m)
    );

    fixed_leaky_relu_pipelined #(.ROUNDING(1)) dut_round (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(in_vld), .data_in_0_ready(in_rdy1),
        .data_out_0(dout1), .data_out_0_valid(ov1), .data_out_0_ready(out_rdy),
        .cfg_valid(cfg_v), .cfg_slope(cfg_s), .cfg_mode(cfg_m)
    );

    fixed_leaky_relu_pipelined #(.DATA_OUT_0_PRECISION_0(6)) dut_w6 (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(in_vld), .data_in_0_ready(in_rdy2),
        .data_out_0(dout2), .data_out_0_valid(ov2), .data_out_0_ready(out_rdy),
        .cfg_valid(cfg_v), .cfg_slope(cfg_s), .cfg_mode(cfg_m)
    );

    typedef struct packed {
        logic [3:0][7:0] d0;
        logic [3:0][7:0] d1;
        logic [3:0][7:0] d2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_slope = 13;
    int   m_mode  = 1;
    int   occ = 0;
    int   n_in = 0;
    int   n_out = 0;
    logic last_fire = 1'b0;
    logic stalled = 1'b0;
    logic [7:0] prev0 [N];
    logic [7:0] prev1 [N];
    logic [5:0] prev2 [N];

    // Reference: value in units of 2^-11 (input frac 4 + slope frac 7), then divided down to frac 4.
    function automatic int ref_lane(int x, int slope, int mode, int rnd, int wout);
        longint v, qv;
        longint hi, lo;
        hi = (longint'(1) << (wout - 1)) - 1;
        lo = -(longint'(1) << (wout - 1));
        if (x < 0 && mode == 0) return 0;
        if (x < 0 && mode == 1) v = longint'(x) * slope;
        else                    v = longint'(x) * 128;
        if (rnd != 0) v = v + 64;
        qv = v / 128;
        if ((v % 128) != 0 && v < 0) qv = qv - 1;
        if (qv > hi) qv = hi;
        if (qv < lo) qv = lo;
        return int'(qv);
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk4(string tag, int inst, int e0, int e1, int e2, int e3);
        int ev [4];
        ev = '{e0, e1, e2, e3};
        for (int i = 0; i < N; i++) begin
            if (inst == 0)      chk(tag, 32'($signed(dout0[i])), ev[i]);
            else if (inst == 1) chk(tag, 32'($signed(dout1[i])), ev[i]);
            else                chk(tag, 32'($signed(dout2[i])), ev[i]);
        end
    endtask

    task automatic set_din(int a, int b, int c, int d);
        din[0] = 8'(a); din[1] = 8'(b); din[2] = 8'(c); din[3] = 8'(d);
    endtask

    task automatic rand_din();
        for (int i = 0; i < N; i++) din[i] = 8'($urandom);
    endtask

    // One clock: check outputs at negedge against the scoreboard, update the model, then advance.
    task automatic step();
        logic in_fire, out_fire, exp_rdy;
        exp_t e;
        int   x;
        @(negedge clk);
        if (!rst) begin
            exp_rdy = !(occ == 2 && !out_rdy);
            chk("in_ready_floor", 32'(in_rdy0), 32'(exp_rdy));
            chk("in_ready_round", 32'(in_rdy1), 32'(exp_rdy));
            chk("in_ready_w6",    32'(in_rdy2), 32'(exp_rdy));
            if (stalled) begin
                chk("stall_valid", 32'(ov0), 1);
                for (int i = 0; i < N; i++) begin
                    chk("stall_data_floor", 32'(dout0[i]), 32'(prev0[i]));
                    chk("stall_data_round", 32'(dout1[i]), 32'(prev1[i]));
                    chk("stall_data_w6",    32'(dout2[i]), 32'(prev2[i]));
                end
            end
            if (ov0) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(ov0), 0);
                end else begin
                    e = q[0];
                    chk("valid_round", 32'(ov1), 1);
                    chk("valid_w6",    32'(ov2), 1);
                    for (int i = 0; i < N; i++) begin
                        chk("data_floor", 32'($signed(dout0[i])), 32'($signed(e.d0[i])));
                        chk("data_round", 32'($signed(dout1[i])), 32'($signed(e.d1[i])));
                        chk("data_w6",    32'($signed(dout2[i])), 32'($signed(e.d2[i][5:0])));
                    end
                end
            end
            in_fire  = in_vld && in_rdy0;
            out_fire = ov0 && out_rdy;
            if (in_fire) begin
                for (int i = 0; i < N; i++) begin
                    x = int'($signed(din[i]));
                    e.d0[i] = 8'(ref_lane(x, m_slope, m_mode, 0, 8));
                    e.d1[i] = 8'(ref_lane(x, m_slope, m_mode, 1, 8));
                    e.d2[i] = 8'(ref_lane(x, m_slope, m_mode, 0, 6));
                end
                q.push_back(e);
            end
            if (out_fire && q.size() > 0) void'(q.pop_front());
            occ = occ + int'(in_fire) - int'(out_fire);
            n_in  = n_in + int'(in_fire);
            n_out = n_out + int'(out_fire);
            if (cfg_v) begin
                m_slope = int'($signed(cfg_s));
                m_mode  = int'(cfg_m);
            end
            stalled = ov0 && !out_rdy;
            for (int i = 0; i < N; i++) begin
                prev0[i] = dout0[i]; prev1[i] = dout1[i]; prev2[i] = dout2[i];
            end
            last_fire = in_fire;
        end else begin
            q.delete();
            occ = 0; m_slope = 13; m_mode = 1;
            stalled = 1'b0; last_fire = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_in0, n_out0;
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
        cfg_v = 1'b0; cfg_s = 8'd0; cfg_m = 2'b00;
        set_din(0, 0, 0, 0);
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(ov0), 0);
        chk("rst_ready", 32'(in_rdy0), 1);
        chk4("rst_data_floor", 0, 0, 0, 0, 0);
        chk4("rst_data_w6", 2, 0, 0, 0, 0);

        // Default LeakyReLU, floor vs round-half-up, 2-cycle latency
        set_din(-4, -5, -16, 20); in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        chk("latency_c1", 32'(ov0), 0);
        step();
        chk("latency_c2", 32'(ov0), 1);
        chk4("leaky_floor", 0, -1, -1, -2, 20);
        chk4("leaky_round", 1, 0, -1, -2, 20);
        step();

        // Config in the same cycle as beat A applies only from beat B
        cfg_v = 1'b1; cfg_m = 2'b00; cfg_s = 8'd13;
        set_din(-3, 5, -1, 0); in_vld = 1'b1;
        step();
        cfg_v = 1'b0;
        step();
        in_vld = 1'b0;
        chk4("cfg_old_A", 0, -1, 5, -1, 0);
        step();
        chk4("cfg_new_B", 0, 0, 5, 0, 0);
        step();

        // Identity saturation on a 6-bit output
        cfg_v = 1'b1; cfg_m = 2'b10;
        step();
        cfg_v = 1'b0;
        set_din(127, -128, 0, 0); in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        chk4("ident_w6_sat", 2, 31, -32, 0, 0);
        chk4("ident_w8", 0, 127, -128, 0, 0);
        step();

        // Most negative slope times most negative input saturates positive
        cfg_v = 1'b1; cfg_m = 2'b01; cfg_s = 8'h80;
        step();
        cfg_v = 1'b0;
        set_din(-128, 0, 0, 0); in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        chk4("neg_slope_sat", 0, 127, 0, 0, 0);
        step();

        cfg_v = 1'b1; cfg_m = 2'b01; cfg_s = 8'd13;
        step();
        cfg_v = 1'b0;

        // 10-beat stream with downstream ready pattern 1,0,0,1
        n_in0 = n_in; n_out0 = n_out;
        rand_din(); in_vld = 1'b1;
        for (int c = 0; c < 200 && (n_out - n_out0) < 10; c++) begin
            out_rdy = (c % 4 == 0) || (c % 4 == 3);
            if (n_in - n_in0 >= 10) in_vld = 1'b0;
            step();
            if (last_fire) rand_din();
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        chk("stream_in_count", n_in - n_in0, 10);
        chk("stream_out_count", n_out - n_out0, 10);

        // Reset with two beats in flight under a non-default config
        cfg_v = 1'b1; cfg_m = 2'b00; cfg_s = 8'd50;
        step();
        cfg_v = 1'b0; out_rdy = 1'b0;
        rand_din(); in_vld = 1'b1;
        step();
        rand_din();
        step();
        in_vld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; out_rdy = 1'b1;
        chk("midrst_valid", 32'(ov0), 0);
        chk("midrst_ready", 32'(in_rdy0), 1);
        set_din(-4, -5, -16, 20); in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        chk4("midrst_default_cfg", 0, -1, -1, -2, 20);
        step();

        // Random traffic, random backpressure and occasional reconfiguration
        for (int c = 0; c < 400; c++) begin
            if (!in_vld || last_fire) begin
                in_vld = ($urandom_range(0, 3) != 0);
                rand_din();
            end
            out_rdy = ($urandom_range(0, 2) != 0);
            cfg_v   = ($urandom_range(0, 19) == 0);
            cfg_s   = 8'($urandom);
            cfg_m   = 2'($urandom);
            step();
        end
        cfg_v = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) step();
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
